// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable, line/frame strobes and
// blank-zeroed pixel coordinates. Define VGA_TIMING_FRAME_COUNT_EN to add a 16-bit frame counter.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int X_W      = 11,
   parameter int Y_W      = 10
) (
   input  logic           vga_clk_in,
   input  logic           reset_in,
   input  logic           ce_in,
   output logic           h_sync_out,
   output logic           v_sync_out,
   output logic           display_on_out,
   output logic [X_W-1:0] pixel_x_out,
   output logic [Y_W-1:0] pixel_y_out,
   output logic           line_start_out,
   output logic           frame_start_out
`ifdef VGA_TIMING_FRAME_COUNT_EN
   ,
   output logic [15:0]    frame_count_out
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] H_ACT_C  = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] V_ACT_C  = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

   // Elaboration-time sanity of the timing parameters and counter widths.
   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
      $error("vga_timing_gen: timing parameters must all be non-zero");
   end
   if (longint'(H_TOTAL) > (longint'(1) << X_W)) begin : g_x_too_narrow
      $error("vga_timing_gen: X_W too narrow for H_TOTAL");
   end
   if (longint'(V_TOTAL) > (longint'(1) << Y_W)) begin : g_y_too_narrow
      $error("vga_timing_gen: Y_W too narrow for V_TOTAL");
   end

   logic [X_W-1:0] h_q, h_d, px_q, px_d;
   logic [Y_W-1:0] v_q, v_d, py_q, py_d;
   logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
   logic           hs_act, vs_act;
`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [15:0]    fc_q, fc_d;
`endif

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + Y_W'(1);
      end else begin
         h_d = h_q + X_W'(1);
      end

      // Outputs decode the current counter state, so they trail the counter by one ce edge.
      de_d   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
      hs_act = (h_q >= HS_START) && (h_q < HS_END);
      vs_act = (v_q >= VS_START) && (v_q < VS_END);
      hs_d   = H_POL ? hs_act : ~hs_act;
      vs_d   = V_POL ? vs_act : ~vs_act;
      px_d   = de_d ? h_q : '0;
      py_d   = de_d ? v_q : '0;
      ls_d   = (h_q == '0);
      fs_d   = ls_d && (v_q == '0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
      fc_d   = fs_d ? fc_q + 16'd1 : fc_q;
`endif
   end

   always_ff @(posedge vga_clk_in) begin
      if (reset_in) begin
         h_q  <= '0;
         v_q  <= '0;
         hs_q <= ~H_POL;
         vs_q <= ~V_POL;
         de_q <= 1'b0;
         px_q <= '0;
         py_q <= '0;
         ls_q <= 1'b0;
         fs_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
         fc_q <= '0;
`endif
      end else if (ce_in) begin
         h_q  <= h_d;
         v_q  <= v_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
         px_q <= px_d;
         py_q <= py_d;
         ls_q <= ls_d;
         fs_q <= fs_d;
`ifdef VGA_TIMING_FRAME_COUNT_EN
         fc_q <= fc_d;
`endif
      end
   end

   assign h_sync_out      = hs_q;
   assign v_sync_out      = vs_q;
   assign display_on_out  = de_q;
   assign pixel_x_out     = px_q;
   assign pixel_y_out     = py_q;
   assign line_start_out  = ls_q;
   assign frame_start_out = fs_q;
`ifdef VGA_TIMING_FRAME_COUNT_EN
   assign frame_count_out = fc_q;
`endif

endmodule
